// File: rtl/zap_tlb_assoc_mem_pkg.sv
// Shared types, widths and helper functions for the set-associative TLB store.
// The invalidate-by-VA state encoding sits here next to the VA width.
package zap_tlb_assoc_mem_pkg;

    localparam int unsigned VA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_CLR  = 2'd2
    } inv_state_t;

    function automatic int unsigned f_clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

    // A single-way store still carries a 1-bit way field.
    function automatic int unsigned f_way_w(input int unsigned ways);
        return (ways > 1) ? f_clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/zap_tlb_assoc_mem_if.sv
// Command/result bundle of the set-associative TLB store.
// Signal names match the original flat port list.
interface zap_tlb_assoc_mem_if #(
    parameter int unsigned DATA_WDT = 32,
    parameter int unsigned WAY_W    = 1
);
    logic                i_rd_en;
    logic [31:0]         i_rd_va;
    logic                i_wr_en;
    logic [31:0]         i_wr_va;
    logic [DATA_WDT-1:0] i_wr_data;
    logic                i_inv_all;
    logic                i_inv_va_en;
    logic [31:0]         i_inv_va;
    logic                o_rdav;
    logic                o_hit;
    logic [WAY_W-1:0]    o_hit_way;
    logic [DATA_WDT-1:0] o_rdata;
    logic                o_busy;

    modport master (
        output i_rd_en, i_rd_va, i_wr_en, i_wr_va, i_wr_data,
               i_inv_all, i_inv_va_en, i_inv_va,
        input  o_rdav, o_hit, o_hit_way, o_rdata, o_busy
    );

    modport slave (
        input  i_rd_en, i_rd_va, i_wr_en, i_wr_va, i_wr_data,
               i_inv_all, i_inv_va_en, i_inv_va,
        output o_rdav, o_hit, o_hit_way, o_rdata, o_busy
    );

endinterface

// File: rtl/zap_tlb_victim_sel.sv
// Fill way choice for one set: existing match, else lowest free way, else the
// set's round-robin pointer, which advances only when it is actually used.
module zap_tlb_victim_sel
    import zap_tlb_assoc_mem_pkg::*;
#(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned SETS  = 8,
    parameter int unsigned IDX_W = f_clog2(SETS),
    parameter int unsigned WAY_W = f_way_w(WAYS)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WAYS-1:0]  i_valid,
    input  logic [WAYS-1:0]  i_match,
    input  logic             i_fill,
    input  logic [IDX_W-1:0] i_set,
    input  logic             i_clr_all,
    output logic [WAY_W-1:0] o_victim
);

    logic [WAY_W-1:0] r_ptr [SETS];

    logic             w_any_match;
    logic             w_any_free;
    logic             w_use_rr;
    logic [WAY_W-1:0] w_match_way;
    logic [WAY_W-1:0] w_free_way;

    always_comb begin
        w_any_match = 1'b0;
        w_match_way = '0;
        w_any_free  = 1'b0;
        w_free_way  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (i_match[w] && !w_any_match) begin
                w_any_match = 1'b1;
                w_match_way = WAY_W'(w);
            end
            if (!i_valid[w] && !w_any_free) begin
                w_any_free = 1'b1;
                w_free_way = WAY_W'(w);
            end
        end
    end

    assign w_use_rr = !w_any_match && !w_any_free;
    assign o_victim = w_any_match ? w_match_way :
                      w_any_free  ? w_free_way  : r_ptr[i_set];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned s = 0; s < SETS; s++) r_ptr[s] <= '0;
        end else if (i_clr_all) begin
            for (int unsigned s = 0; s < SETS; s++) r_ptr[s] <= '0;
        end else if (i_fill && w_use_rr) begin
            r_ptr[i_set] <= (r_ptr[i_set] == WAY_W'(WAYS - 1)) ? '0 : r_ptr[i_set] + 1'b1;
        end
    end

endmodule

// File: rtl/zap_tlb_assoc_mem.sv
// N-way set-associative TLB store for one page size: registered tag-matched
// lookup, round-robin fill, invalidate-all and a 2-cycle invalidate-by-VA FSM.
module zap_tlb_assoc_mem
    import zap_tlb_assoc_mem_pkg::*;
#(
    parameter int unsigned WAYS     = 2,
    parameter int unsigned SETS     = 8,
    parameter int unsigned VA_LSB   = 20,
    parameter int unsigned DATA_WDT = 32
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    zap_tlb_assoc_mem_if.slave bus
);

    localparam int unsigned IDX_W = f_clog2(SETS);
    localparam int unsigned TAG_W = VA_W - VA_LSB - IDX_W;
    localparam int unsigned WAY_W = f_way_w(WAYS);

    logic [WAYS-1:0]     r_valid [SETS];
    logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
    logic [DATA_WDT-1:0] r_data  [SETS][WAYS];

    inv_state_t          r_state;
    logic                r_busy;
    logic [IDX_W-1:0]    r_inv_idx;
    logic [TAG_W-1:0]    r_inv_tag;
    logic [WAYS-1:0]     r_inv_mask;

    logic                r_rdav;
    logic                r_hit;
    logic [WAY_W-1:0]    r_hit_way;
    logic [DATA_WDT-1:0] r_rdata;

    logic [IDX_W-1:0]    w_rd_idx, w_wr_idx, w_inv_idx;
    logic [TAG_W-1:0]    w_rd_tag, w_wr_tag, w_inv_tag;
    logic                w_rd_acc, w_wr_acc, w_inv_start;
    logic [WAYS-1:0]     w_rd_match, w_wr_match, w_cmp_match;
    logic                w_rd_hit;
    logic [WAY_W-1:0]    w_rd_way;
    logic [DATA_WDT-1:0] w_rd_data;
    logic [WAY_W-1:0]    w_victim;
    logic                w_unused;

    assign w_rd_idx  = bus.i_rd_va[VA_LSB +: IDX_W];
    assign w_wr_idx  = bus.i_wr_va[VA_LSB +: IDX_W];
    assign w_inv_idx = bus.i_inv_va[VA_LSB +: IDX_W];
    assign w_rd_tag  = bus.i_rd_va[VA_W-1 -: TAG_W];
    assign w_wr_tag  = bus.i_wr_va[VA_W-1 -: TAG_W];
    assign w_inv_tag = bus.i_inv_va[VA_W-1 -: TAG_W];
    assign w_unused  = ^{bus.i_rd_va[VA_LSB-1:0], bus.i_wr_va[VA_LSB-1:0],
                         bus.i_inv_va[VA_LSB-1:0]};

    // Lookups are read-only, so only busy blocks them; invalidate-all just
    // forces the registered result to a miss.
    assign w_inv_start = bus.i_inv_va_en && !bus.i_inv_all && (r_state == ST_IDLE);
    assign w_rd_acc    = bus.i_rd_en && !r_busy;
    assign w_wr_acc    = bus.i_wr_en && !r_busy && !bus.i_inv_all && !w_inv_start;

    always_comb begin
        w_rd_match  = '0;
        w_wr_match  = '0;
        w_cmp_match = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            w_rd_match[w]  = r_valid[w_rd_idx][w]  && (r_tag[w_rd_idx][w]  == w_rd_tag);
            w_wr_match[w]  = r_valid[w_wr_idx][w]  && (r_tag[w_wr_idx][w]  == w_wr_tag);
            w_cmp_match[w] = r_valid[r_inv_idx][w] && (r_tag[r_inv_idx][w] == r_inv_tag);
        end
    end

    always_comb begin
        w_rd_hit  = 1'b0;
        w_rd_way  = '0;
        w_rd_data = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (w_rd_match[w] && !w_rd_hit) begin
                w_rd_hit  = 1'b1;
                w_rd_way  = WAY_W'(w);
                w_rd_data = r_data[w_rd_idx][w];
            end
        end
    end

    zap_tlb_victim_sel #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_valid   (r_valid[w_wr_idx]),
        .i_match   (w_wr_match),
        .i_fill    (w_wr_acc),
        .i_set     (w_wr_idx),
        .i_clr_all (bus.i_inv_all),
        .o_victim  (w_victim)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else if (bus.i_inv_all) begin
            for (int unsigned s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else begin
            if (r_state == ST_CLR) r_valid[r_inv_idx] <= r_valid[r_inv_idx] & ~r_inv_mask;
            if (w_wr_acc) r_valid[w_wr_idx][w_victim] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_tag[w_wr_idx][w_victim]  <= w_wr_tag;
            r_data[w_wr_idx][w_victim] <= bus.i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_inv_idx  <= '0;
            r_inv_tag  <= '0;
            r_inv_mask <= '0;
            r_rdav     <= 1'b0;
            r_hit      <= 1'b0;
            r_hit_way  <= '0;
            r_rdata    <= '0;
        end else begin
            r_rdav <= w_rd_acc;
            if (w_rd_acc) begin
                r_hit     <= w_rd_hit && !bus.i_inv_all;
                r_hit_way <= bus.i_inv_all ? '0 : w_rd_way;
                r_rdata   <= bus.i_inv_all ? '0 : w_rd_data;
            end
            if (bus.i_inv_all) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_inv_start) begin
                            r_inv_idx <= w_inv_idx;
                            r_inv_tag <= w_inv_tag;
                            r_state   <= ST_CMP;
                            r_busy    <= 1'b1;
                        end
                    end
                    ST_CMP: begin
                        r_inv_mask <= w_cmp_match;
                        r_state    <= ST_CLR;
                    end
                    ST_CLR: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.o_rdav    = r_rdav;
    assign bus.o_hit     = r_hit;
    assign bus.o_hit_way = r_hit_way;
    assign bus.o_rdata   = r_rdata;
    assign bus.o_busy    = r_busy;

endmodule

// File: tb/tb_zap_tlb_assoc_mem.sv
// Directed bench for zap_tlb_assoc_mem with WAYS=2, SETS=4, VA_LSB=20.
// Set 1 VAs used: 0x0010_0000 tag0, 0x0050_0000 tag1, 0x0090_0000 tag2, 0x00D0_0000 tag3.
module tb_zap_tlb_assoc_mem;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 i_clk = ~i_clk;

    zap_tlb_assoc_mem_if #(.DATA_WDT(32), .WAY_W(1)) bus ();

    zap_tlb_assoc_mem #(
        .WAYS     (2),
        .SETS     (4),
        .VA_LSB   (20),
        .DATA_WDT (32)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_rd_en     = 1'b0;
        bus.i_wr_en     = 1'b0;
        bus.i_inv_all   = 1'b0;
        bus.i_inv_va_en = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] va, input logic [31:0] data);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_va   = va;
        bus.i_wr_data = data;
        cyc();
        clear_inputs();
    endtask

    task automatic do_look(input string tag, input logic [31:0] va, input logic hit,
                           input logic way, input logic [31:0] data);
        bus.i_rd_en = 1'b1;
        bus.i_rd_va = va;
        cyc();
        clear_inputs();
        chk({tag, "_rdav"}, bus.o_rdav, 1'b1);
        chk({tag, "_hit"}, bus.o_hit, hit);
        if (hit) chk({tag, "_way"}, bus.o_hit_way, way);
        chk({tag, "_data"}, bus.o_rdata, data);
    endtask

    initial begin
        clear_inputs();
        bus.i_rd_va   = '0;
        bus.i_wr_va   = '0;
        bus.i_wr_data = '0;
        bus.i_inv_va  = '0;
        #12;
        chk("rst_rdav", bus.o_rdav, 1'b0);
        chk("rst_hit", bus.o_hit, 1'b0);
        chk("rst_way", bus.o_hit_way, 1'b0);
        chk("rst_data", bus.o_rdata, 32'h0);
        chk("rst_busy", bus.o_busy, 1'b0);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        do_look("cold", 32'h0010_0000, 1'b0, 1'b0, 32'h0);

        do_fill(32'h0010_0000, 32'hAAAA_0001);
        do_look("fill1", 32'h0010_0000, 1'b1, 1'b0, 32'hAAAA_0001);

        // Duplicate fill reuses way 0; then way 1 free; then RR evicts way 0.
        do_fill(32'h0010_0000, 32'hAAAA_0001);
        do_fill(32'h0050_0000, 32'h5555_0005);
        do_fill(32'h0090_0000, 32'h9999_0009);
        do_look("evict_a", 32'h0010_0000, 1'b0, 1'b0, 32'h0);
        do_look("evict_b", 32'h0050_0000, 1'b1, 1'b1, 32'h5555_0005);
        do_look("evict_c", 32'h0090_0000, 1'b1, 1'b0, 32'h9999_0009);

        // Refill of a present VA together with a lookup: lookup sees old data.
        bus.i_wr_en   = 1'b1;
        bus.i_wr_va   = 32'h0050_0000;
        bus.i_wr_data = 32'hBBBB_0002;
        bus.i_rd_en   = 1'b1;
        bus.i_rd_va   = 32'h0050_0000;
        cyc();
        clear_inputs();
        chk("same_edge_data", bus.o_rdata, 32'h5555_0005);
        do_look("refill", 32'h0050_0000, 1'b1, 1'b1, 32'hBBBB_0002);

        bus.i_inv_va_en = 1'b1;
        bus.i_inv_va    = 32'h0050_0000;
        cyc();
        clear_inputs();
        chk("inv_busy1", bus.o_busy, 1'b1);
        bus.i_rd_en = 1'b1;
        bus.i_rd_va = 32'h0090_0000;
        cyc();
        clear_inputs();
        chk("inv_busy2", bus.o_busy, 1'b1);
        chk("inv_rd_blocked", bus.o_rdav, 1'b0);
        cyc();
        chk("inv_done", bus.o_busy, 1'b0);
        do_look("inv_gone", 32'h0050_0000, 1'b0, 1'b0, 32'h0);
        do_look("inv_keep", 32'h0090_0000, 1'b1, 1'b0, 32'h9999_0009);

        // RR pointer must still be 1 after the matching refill.
        do_fill(32'h0050_0000, 32'hBBBB_0002);
        do_fill(32'h00D0_0000, 32'hDDDD_000D);
        do_look("rr_new", 32'h00D0_0000, 1'b1, 1'b1, 32'hDDDD_000D);
        do_look("rr_keep", 32'h0090_0000, 1'b1, 1'b0, 32'h9999_0009);
        do_look("rr_evict", 32'h0050_0000, 1'b0, 1'b0, 32'h0);

        // Pointer 0 -> 1 by evicting way 0, then invalidate-all resets it.
        do_fill(32'h0010_0000, 32'h1000_0001);
        bus.i_inv_all = 1'b1;
        bus.i_rd_en   = 1'b1;
        bus.i_rd_va   = 32'h00D0_0000;
        cyc();
        clear_inputs();
        chk("ia_rdav", bus.o_rdav, 1'b1);
        chk("ia_hit", bus.o_hit, 1'b0);
        chk("ia_data", bus.o_rdata, 32'h0);
        do_look("ia_after", 32'h0010_0000, 1'b0, 1'b0, 32'h0);
        do_fill(32'h0050_0000, 32'h5555_0005);
        do_fill(32'h0090_0000, 32'h9999_0009);
        do_fill(32'h00D0_0000, 32'hDDDD_000D);
        do_look("ia_rr_reset", 32'h00D0_0000, 1'b1, 1'b0, 32'hDDDD_000D);

        // Invalidate-all during CMP aborts the FSM.
        bus.i_inv_va_en = 1'b1;
        bus.i_inv_va    = 32'h0090_0000;
        cyc();
        clear_inputs();
        chk("abort_busy", bus.o_busy, 1'b1);
        bus.i_inv_all = 1'b1;
        cyc();
        clear_inputs();
        chk("abort_idle", bus.o_busy, 1'b0);
        do_look("abort_miss_a", 32'h0090_0000, 1'b0, 1'b0, 32'h0);
        do_look("abort_miss_b", 32'h00D0_0000, 1'b0, 1'b0, 32'h0);

        // Reset asserted in CLR clears outputs asynchronously.
        do_fill(32'h0010_0000, 32'h1234_5678);
        bus.i_rd_en     = 1'b1;
        bus.i_rd_va     = 32'h0010_0000;
        bus.i_inv_va_en = 1'b1;
        bus.i_inv_va    = 32'h0010_0000;
        cyc();
        clear_inputs();
        chk("pre_rst_hit", bus.o_hit, 1'b1);
        chk("pre_rst_data", bus.o_rdata, 32'h1234_5678);
        cyc();
        chk("pre_rst_busy", bus.o_busy, 1'b1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_rdav", bus.o_rdav, 1'b0);
        chk("arst_hit", bus.o_hit, 1'b0);
        chk("arst_way", bus.o_hit_way, 1'b0);
        chk("arst_data", bus.o_rdata, 32'h0);
        chk("arst_busy", bus.o_busy, 1'b0);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        do_look("post_rst", 32'h0010_0000, 1'b0, 1'b0, 32'h0);
        chk("post_rst_busy", bus.o_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/zap_tlb_assoc_mem.md
# zap_tlb_assoc_mem

Parametrised N-way set-associative TLB store. It is the successor to the direct-mapped, single-cycle-clearing TLB memory used for each page size (section, large page, small page) in the MMU. Each instance holds one page size and performs tag matching internally, so the downstream TLB check logic receives a hit flag instead of raw entries. It adds three behaviours: associativity with per-set round-robin replacement, invalidate-by-VA, and a registered lookup with an explicit data-valid strobe.

## Interface
- WAYS, 2: associativity; power of 2, 1..8.
- SETS, 8: sets per way; power of 2, 2..64.
- VA_LSB, 20: VA bit position of the lowest index bit (20 section, 16 large page, 12 small page).
- DATA_WDT, 32: entry payload width, which is the descriptor fields the TLB check consumes.
- i_clk  in  1  core clock; single clock domain.
- i_reset_n  in  1  asynchronous active-low reset.
- i_rd_en  in  1  lookup request.
- i_rd_va  in  32  lookup VA; this is the next-cycle address.
- i_wr_en  in  1  fill request.
- i_wr_va  in  32  fill VA.
- i_wr_data  in  DATA_WDT  fill payload.
- i_inv_all  in  1  invalidate-all pulse.
- i_inv_va_en  in  1  invalidate-by-VA request.
- i_inv_va  in  32  VA to invalidate.
- o_rdav  out  1  lookup result valid.
- o_hit  out  1  lookup hit.
- o_hit_way  out  clog2(WAYS) max 1  way that hit.
- o_rdata  out  DATA_WDT  payload of the hit way; 0 on miss.
- o_busy  out  1  invalidate-by-VA in progress.

## Operation
- Address split:
  - index = va[VA_LSB +: IDX_W], where IDX_W = clog2(SETS).
  - tag = va[31 : VA_LSB+IDX_W].
  - Storage per entry is valid + tag + data, all in flops.
- Command priority, evaluated each edge: i_inv_all > i_inv_va_en > i_wr_en > i_rd_en.
- Lookup:
  - On an edge with i_rd_en=1 and o_busy=0, compare the tag against all ways of the indexed set.
  - Register o_rdav=1, o_hit, o_hit_way and o_rdata.
  - A lookup in the same edge as a fill to the same set returns the pre-fill contents.
  - A lookup in the same edge as i_inv_all returns o_hit=0.
  - o_rdav deasserts on any edge without an accepted lookup. Result outputs hold their value until the next accepted lookup.
- Fill: victim selection for the indexed set, in order:
  1. The way whose valid tag already matches; no duplicates are allowed.
  2. Otherwise the lowest-numbered invalid way.
  3. Otherwise the way at the set's round-robin pointer.
  - The pointer advances (mod WAYS) only when case 3 is used.
  - Fills and lookups are ignored while o_busy=1.
- Invalidate-all: clears every valid bit and resets every RR pointer to 0 at the edge. It aborts any invalidate-by-VA in progress (FSM returns to IDLE).
- Invalidate-by-VA FSM:
  - IDLE: on i_inv_va_en, capture the VA and go to CMP. o_busy=1 from the next cycle.
  - CMP: compare all ways of the captured set, register the match mask, go to CLR.
  - CLR: clear the valid bits in the mask, go to IDLE. o_busy=0 from the following cycle.
  - A request to a VA not present completes identically with no state change.
  - i_inv_va_en while busy is ignored.
- Reset (async, i_reset_n=0):
  - All valid bits, RR pointers, o_rdav, o_hit, o_hit_way, o_rdata and o_busy go to 0.
  - FSM goes to IDLE.
  - Tag and data flops are not reset.

## Timing
- Lookup latency is 1 cycle: request at edge N, result valid after edge N, sampled at edge N+1. One lookup per cycle, fully pipelined.
- A fill is visible to a lookup accepted at the edge after the fill edge.
- Invalidate-by-VA occupancy is 2 cycles busy (CMP, CLR). A new request is accepted on the edge after o_busy falls.
- Invalidate-all takes effect in a single edge; the next-edge lookup misses.
- Reset asserted mid-FSM forces IDLE immediately and asynchronously.

## Structure
- Widths IDX_W and TAG_W are derived as localparams. The FSM state encodings (IDLE/CMP/CLR) go in the shared localparams include, alongside the existing TLB width defines.
- clog2 comes from the shared functions include.
- One sub-module: zap_tlb_victim_sel. It is combinational plus the per-set RR pointer registers, with inputs valid vector, match vector and fill strobe, and output victim way.

## Test plan
All scenarios use WAYS=2, SETS=4, VA_LSB=20, DATA_WDT=32.
- Reset, then lookup VA 0x0010_0000 -> o_rdav=1, o_hit=0, o_rdata=0.
- Fill VA 0x0010_0000 with data 0xAAAA_0001, then lookup the same VA next cycle -> o_hit=1, o_hit_way=0, o_rdata=0xAAAA_0001.
- Fill VAs 0x0010_0000, 0x0050_0000 and 0x0090_0000 (all set 1) -> third fill evicts way 0. Lookup 0x0010_0000 misses; 0x0050_0000 hits way 1; 0x0090_0000 hits way 0.
- Refill 0x0050_0000 with 0xBBBB_0002 -> same way 1 is overwritten and the RR pointer is unchanged.
- Invalidate-by-VA 0x0050_0000 -> o_busy high 2 cycles; a lookup issued while busy gives o_rdav=0. After busy falls, 0x0050_0000 misses and 0x0090_0000 still hits.
- i_inv_all in the same cycle as a lookup of a present VA, and separately during CMP -> o_hit=0, FSM back to IDLE, all subsequent lookups miss. Also assert i_reset_n=0 mid-CLR -> all outputs 0 immediately.
